pim_conv_ctrl: RTL and testbench
================================

# pim_conv_ctrl

Bit-serial sequencer for one PIM crossbar column-readout datapath. It accepts a multi-bit input feature vector over a valid/ready handshake and drives the crossbar one bit plane at a time. For each plane it scans every column address and shift-accumulates the ADC results per column. It then streams the DEPTH column sums to the downstream pooling/activation stage.

## Interface
- INPUT_SIZE, 32, crossbar rows (feature vector length)
- INPUT_P, 4, feature element precision (bit planes)
- DEPTH, 32, crossbar columns scanned per plane
- ADC_P, 4, ADC result width
- AW (derived), clogb2(DEPTH), column address width
- ACC_W (derived), ADC_P+INPUT_P, accumulator/result width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  feature vector offered
- in_ready  out  1  controller can take a feature
- in_feature  in  INPUT_SIZE*INPUT_P  element i at [i*INPUT_P +: INPUT_P]
- xb_en  out  1  crossbar compute strobe (bit plane applied)
- xb_bits  out  INPUT_SIZE  current bit plane, bit i = element i bit b
- xb_addr  out  AW  column address for ADC readout
- xb_data  in  ADC_P  ADC result, valid one cycle after xb_addr
- out_valid  out  1  column result available
- out_ready  in  1  downstream accepts
- out_data  out  ACC_W  weighted column sum
- out_col  out  AW  column index of out_data
- out_last  out  1  high on column DEPTH-1 beat
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, SCAN, FLUSH, EMIT.
- IDLE: in_ready=1. On in_valid&in_ready, register the feature, set plane b=0, and go to LOAD.
- LOAD (1 cycle): xb_en=1, xb_bits=plane b, then go to SCAN with addr=0.
- SCAN (DEPTH cycles): xb_addr=0..DEPTH-1, one address per cycle. xb_data for address a-1 is captured in the cycle address a is driven. After addr DEPTH-1, go to FLUSH.
- FLUSH (1 cycle): capture data for column DEPTH-1. If b<INPUT_P-1, increment b and go to LOAD. Otherwise go to EMIT with col=0.
- Accumulate: on plane 0, acc[c] = xb_data (overwrite, so no clear pass is needed). On plane b>0, acc[c] = acc[c] + (xb_data << b). Planes are processed LSB first.
- Width: ACC_W holds the maximum (2^ADC_P-1)(2^INPUT_P-1) with no saturation logic.
- EMIT: out_valid=1, out_data=acc[col], out_col=col, out_last=(col==DEPTH-1). On handshake, col increments. After the last handshake, go to IDLE.
- Control outputs outside their states:
  - xb_bits=0 and xb_en=0 outside LOAD.
  - xb_addr holds 0 outside SCAN.
- Reset, asserted in any state including mid-SCAN or mid-EMIT: next state is IDLE and the in-flight feature is discarded. Accumulator contents are don't-care.

## Timing
- Reset values: in_ready=0 during reset and 1 in IDLE afterwards. xb_en=0, xb_bits=0, xb_addr=0, out_valid=0, out_data=0, out_col=0, out_last=0, busy=0.
- Compute latency, from accept to first out_valid: INPUT_P*(DEPTH+2) cycles, plus 1 for the IDLE to LOAD step. With defaults this is 137.
- EMIT takes at least DEPTH cycles. Under backpressure, out_data, out_col and out_last stay stable while out_valid&!out_ready.
- in_ready is low from accept until the cycle after the out_last handshake, so features are not overlapped.
- The ADC latency is fixed at 1 cycle and the controller does not check it.

## Structure
- Package pim_pkg: clogb2 function, ACC_W/AW derivation, state enum.
- Sub-module pim_acc_buf: DEPTH×ACC_W register file with one synchronous write port (SCAN/FLUSH) and one read port (accumulate read-modify-write and EMIT). Read is combinational.
- Everything else (FSM, plane and address counters, shifter) stays in pim_conv_ctrl.

## Test plan
The bench uses INPUT_P=4, DEPTH=4, ADC_P=4. The crossbar model returns, with 1-cycle latency, popcount(xb_bits & W[addr]) saturated at 15, where W is the latched weight column.
- Reset: hold rst=0 for 3 cycles, then release. All outputs are at their reset values and in_ready=1 in the first post-reset cycle.
- Zero feature with any W: 4 beats, out_data=0, out_col=0..3, out_last only on col 3.
- Element 0 = 4'hF, W[2] row 0 = 1, everything else 0: col2 out_data=15, all other columns 0.
- Model forced to return 15 on every read: every column out_data=225, with no wrap at ACC_W=8.
- Backpressure: out_ready pattern 0,1,0,0,1,1,0,1. Beats arrive in order 0..3 with none dropped or duplicated and data stable while stalled. in_ready rises only after the col 3 handshake.
- Reset asserted during SCAN of plane 2: the next cycle is IDLE with xb_en=0 and out_valid=0. A following element-0 = 4'h5 feature with W[0] row 0 = 1 gives col0=5.

Source files
------------

// File: rtl/pim_pkg.sv
// Shared types and width helpers for the PIM convolution controller.
package pim_pkg;

  // Ceiling log2, never below 1 so single-entry ranges still get a usable bus.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return (res == 0) ? 1 : res;
  endfunction

  // Worst-case column sum is (2^adc_p-1)*(2^input_p-1), which fits in adc_p+input_p bits.
  function automatic int unsigned acc_width(input int unsigned adc_p, input int unsigned input_p);
    return adc_p + input_p;
  endfunction

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StScan,
    StFlush,
    StEmit
  } state_e;

endpackage

// File: rtl/pim_acc_buf.sv
// Per-column accumulator storage: one synchronous write port, one combinational read port.
module pim_acc_buf #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [ACC_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [ACC_W-1:0] rdata
);

  logic [ACC_W-1:0] mem_q [DEPTH];

  // Contents need no reset: plane 0 overwrites every column before any read-back.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pim_conv_ctrl.sv
// Bit-serial crossbar sequencer: applies one bit plane at a time, scans every column,
// shift-accumulates the ADC results per column, then streams the column sums out.
module pim_conv_ctrl
  import pim_pkg::*;
#(
  parameter int unsigned INPUT_SIZE = 32,
  parameter int unsigned INPUT_P    = 4,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADC_P      = 4,
  localparam int unsigned AW        = clogb2(DEPTH),
  localparam int unsigned ACC_W     = acc_width(ADC_P, INPUT_P)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INPUT_SIZE*INPUT_P-1:0] in_feature,
  output logic                          xb_en,
  output logic [INPUT_SIZE-1:0]         xb_bits,
  output logic [AW-1:0]                 xb_addr,
  input  logic [ADC_P-1:0]              xb_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_data,
  output logic [AW-1:0]                 out_col,
  output logic                          out_last,
  output logic                          busy
);

  localparam int unsigned PW = clogb2(INPUT_P);
  localparam logic [PW-1:0] LastPlane = PW'(INPUT_P - 1);
  localparam logic [AW-1:0] LastCol   = AW'(DEPTH - 1);

  state_e                        state_q, state_d;
  logic [INPUT_SIZE*INPUT_P-1:0] feat_q;
  logic [PW-1:0]                 plane_q, plane_d;
  logic [AW-1:0]                 addr_q, addr_d;
  logic [AW-1:0]                 col_q, col_d;
  logic                          feat_load;

  logic                          acc_we;
  logic [AW-1:0]                 wr_col, rd_col;
  logic [ACC_W-1:0]              acc_rd, acc_wr;
  logic [INPUT_SIZE-1:0]         plane_bits;

  // State and counter registers; reset drops any in-flight feature.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      feat_q  <= '0;
      plane_q <= '0;
      addr_q  <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      if (feat_load) begin
        feat_q <= in_feature;
      end
    end
  end

  // Next-state, counter updates and handshake/strobe outputs.
  always_comb begin
    state_d   = state_q;
    plane_d   = plane_q;
    addr_d    = addr_q;
    col_d     = col_q;
    feat_load = 1'b0;
    in_ready  = 1'b0;
    xb_en     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    acc_we    = 1'b0;
    wr_col    = '0;
    case (state_q)
      StIdle: begin
        busy     = 1'b0;
        in_ready = rst;
        if (in_valid) begin
          feat_load = 1'b1;
          plane_d   = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        xb_en   = 1'b1;
        addr_d  = '0;
        state_d = StScan;
      end
      StScan: begin
        // ADC answers one cycle late, so this cycle writes the previous column.
        if (addr_q != '0) begin
          acc_we = 1'b1;
          wr_col = addr_q - AW'(1);
        end
        if (addr_q == LastCol) begin
          addr_d  = '0;
          state_d = StFlush;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      StFlush: begin
        acc_we = 1'b1;
        wr_col = LastCol;
        if (plane_q != LastPlane) begin
          plane_d = plane_q + PW'(1);
          state_d = StLoad;
        end else begin
          col_d   = '0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (col_q == LastCol) begin
            col_d   = '0;
            state_d = StIdle;
          end else begin
            col_d = col_q + AW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slice the current bit plane out of the latched feature vector.
  always_comb begin
    logic [INPUT_P-1:0] elem;
    plane_bits = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      elem          = feat_q[i*INPUT_P +: INPUT_P];
      plane_bits[i] = elem[plane_q];
    end
  end

  // Plane 0 overwrites so stale sums from a previous feature never leak in.
  always_comb begin
    if (plane_q == '0) begin
      acc_wr = ACC_W'(xb_data);
    end else begin
      acc_wr = acc_rd + (ACC_W'(xb_data) << plane_q);
    end
  end

  assign rd_col   = (state_q == StEmit) ? col_q : wr_col;

  assign xb_bits  = (state_q == StLoad) ? plane_bits : '0;
  assign xb_addr  = (state_q == StScan) ? addr_q : '0;
  assign out_data = (state_q == StEmit) ? acc_rd : '0;
  assign out_col  = (state_q == StEmit) ? col_q : '0;
  assign out_last = (state_q == StEmit) && (col_q == LastCol);

  pim_acc_buf #(
    .DEPTH (DEPTH),
    .ACC_W (ACC_W),
    .AW    (AW)
  ) u_acc_buf (
    .clk   (clk),
    .we    (acc_we),
    .waddr (wr_col),
    .wdata (acc_wr),
    .raddr (rd_col),
    .rdata (acc_rd)
  );

endmodule

// File: tb/tb_pim_conv_ctrl.sv
// Directed bench for pim_conv_ctrl with a small popcount crossbar model.
module tb_pim_conv_ctrl;

  localparam int unsigned INPUT_SIZE = 8;
  localparam int unsigned INPUT_P    = 4;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned ADC_P      = 4;
  localparam int unsigned AW         = 2;
  localparam int unsigned ACC_W      = 8;
  localparam int unsigned LAT        = INPUT_P * (DEPTH + 2) + 1;

  logic                          clk;
  logic                          rst;
  logic                          in_valid;
  logic                          in_ready;
  logic [INPUT_SIZE*INPUT_P-1:0] in_feature;
  logic                          xb_en;
  logic [INPUT_SIZE-1:0]         xb_bits;
  logic [AW-1:0]                 xb_addr;
  logic [ADC_P-1:0]              xb_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACC_W-1:0]              out_data;
  logic [AW-1:0]                 out_col;
  logic                          out_last;
  logic                          busy;

  logic [INPUT_SIZE-1:0] w_col [DEPTH];
  logic [INPUT_SIZE-1:0] latched_bits;
  logic                  force15;

  int n_checks = 0;
  int n_errors = 0;

  pim_conv_ctrl #(
    .INPUT_SIZE (INPUT_SIZE),
    .INPUT_P    (INPUT_P),
    .DEPTH      (DEPTH),
    .ADC_P      (ADC_P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_feature (in_feature),
    .xb_en      (xb_en),
    .xb_bits    (xb_bits),
    .xb_addr    (xb_addr),
    .xb_data    (xb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ADC_P-1:0] model_read(input logic [AW-1:0] a);
    int cnt;
    if (force15) return 4'd15;
    cnt = $countones(latched_bits & w_col[a]);
    return (cnt > 15) ? 4'd15 : 4'(cnt);
  endfunction

  // Crossbar: latch the plane on xb_en, answer the column address one cycle later.
  always @(posedge clk) begin
    if (xb_en) latched_bits <= xb_bits;
    xb_data <= model_read(xb_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_w(input logic [INPUT_SIZE-1:0] w0, input logic [INPUT_SIZE-1:0] w1,
                       input logic [INPUT_SIZE-1:0] w2, input logic [INPUT_SIZE-1:0] w3);
    w_col[0] = w0;
    w_col[1] = w1;
    w_col[2] = w2;
    w_col[3] = w3;
  endtask

  // Offer a feature from IDLE, check plane strobes and latency, then drain the four beats
  // under the given out_ready pattern (bit k drives emit cycle k, repeating).
  task automatic run_feature(input logic [INPUT_SIZE*INPUT_P-1:0] f,
                             input logic [DEPTH*ACC_W-1:0] exp, input logic [7:0] pat);
    int lat, en_cnt, beats, idx;
    logic stalled;
    logic [INPUT_SIZE-1:0] plane_exp;
    logic [ACC_W-1:0] prev_data;
    logic [AW-1:0] prev_col;
    logic prev_last;
    in_feature = f;
    in_valid   = 1'b1;
    check("idle_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    en_cnt   = 0;
    while (1) begin
      if (xb_en) begin
        if (en_cnt < int'(INPUT_P)) begin
          for (int i = 0; i < INPUT_SIZE; i++) plane_exp[i] = f[i*INPUT_P + en_cnt];
          check("xb_bits", xb_bits, plane_exp);
        end
        en_cnt++;
      end
      if (out_valid || lat >= 200) break;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, LAT);
    check("planes", en_cnt, INPUT_P);
    beats   = 0;
    idx     = 0;
    stalled = 1'b0;
    prev_data = '0;
    prev_col  = '0;
    prev_last = 1'b0;
    for (int cyc = 0; cyc < 64 && beats < int'(DEPTH); cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_ready = pat[idx%8];
      idx++;
      check("in_ready_emit", in_ready, 0);
      if (stalled) begin
        check("stall_data", out_data, prev_data);
        check("stall_col", out_col, prev_col);
        check("stall_last", out_last, prev_last);
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          check("beat_col", out_col, beats);
          check("beat_data", out_data, exp[beats*ACC_W +: ACC_W]);
          check("beat_last", out_last, (beats == int'(DEPTH) - 1));
          beats++;
        end else begin
          stalled   = 1'b1;
          prev_data = out_data;
          prev_col  = out_col;
          prev_last = out_last;
        end
      end
    end
    check("beats", beats, DEPTH);
    @(negedge clk);
    out_ready = 1'b1;
    check("ready_after", in_ready, 1);
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
  endtask

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_feature = '0;
    out_ready  = 1'b1;
    force15    = 1'b0;
    latched_bits = '0;
    set_w('0, '0, '0, '0);

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_in_ready", in_ready, 1);
    check("post_xb_en", xb_en, 0);
    check("post_xb_bits", xb_bits, 0);
    check("post_xb_addr", xb_addr, 0);
    check("post_out_valid", out_valid, 0);
    check("post_out_data", out_data, 0);
    check("post_out_col", out_col, 0);
    check("post_out_last", out_last, 0);
    check("post_busy", busy, 0);

    // Zero feature: all sums zero regardless of weights.
    set_w('1, '1, '1, '1);
    run_feature(32'h0000_0000, 32'h0000_0000, 8'hFF);

    // Element 0 = F, only W[2] row 0 set: col2 = 1+2+4+8.
    set_w('0, '0, 8'h01, '0);
    run_feature(32'h0000_000F, 32'h000F_0000, 8'hFF);

    // Saturated ADC on every read: 15*15 = 225 per column.
    force15 = 1'b1;
    run_feature(32'h1234_5678, 32'hE1E1_E1E1, 8'hFF);
    force15 = 1'b0;

    // Backpressure 0,1,0,0,1,1,0,1 with distinct per-column sums {15,3,18,0}.
    set_w(8'h01, 8'h02, 8'h03, 8'h00);
    run_feature(32'h0000_003F, 32'h0012_030F, 8'b1011_0010);

    // Reset during plane 2 SCAN (accept = cycle 0, plane 2 addr 1 = cycle 15).
    in_feature = 32'h0000_00FF;
    in_valid   = 1'b1;
    check("rs_idle_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("rs_scan_addr", xb_addr, 1);
    check("rs_scan_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rs_xb_en", xb_en, 0);
    check("rs_out_valid", out_valid, 0);
    check("rs_busy", busy, 0);
    check("rs_xb_addr", xb_addr, 0);
    check("rs_in_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    set_w(8'h01, '0, '0, '0);
    run_feature(32'h0000_0005, 32'h0000_0005, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
